// File: rtl/uart_reg_bank.sv
// -----------------------------------------------------------------------------
// uart_reg_bank
//
// Memory-mapped UART register bank for the fwrisc data bus. Holds the TX/RX
// control registers, the baud divisor, sticky error flags and the TX/RX
// character FIFOs that sit between the core and the UART shifters.
//
// Optional feature: define UART_REG_BANK_IRQ_EN to build the IRQ_EN register
// and the registered interrupt output. Without it irq_o is tied low, IRQ_EN
// reads 0 and ignores writes, while IRQ_STAT keeps working.
//
// Ports (uart_reg_bank):
//   clk, rst_n     clock, asynchronous active-low reset
//   daddr_i        bus address (hit when address[31:12] matches BASE_ADDR)
//   dwdata_i       bus write data
//   dstrb_i        byte write strobes
//   dwrite_i       1 = write, 0 = read
//   dvalid_i       request valid, held until dready_o
//   drdata_o       registered read data, valid while dready_o = 1
//   dready_o       one-cycle completion pulse
//   tx_en_o        TX enable (TXCTRL[0])
//   tx_rd_en_i     TX shifter pops one character
//   tx_data_o      TX FIFO head (show-ahead)
//   tx_empty_o     TX FIFO empty
//   rx_en_o        RX enable (RXCTRL[0])
//   rx_wr_en_i     RX shifter pushes one character
//   rx_data_i      received character
//   rx_full_o      RX FIFO full
//   baud_div_o     BAUDDIV register
//   irq_o          registered interrupt
// -----------------------------------------------------------------------------

// Synchronous FIFO with show-ahead output, level count, flush and a drop flag
// for pushes that were refused because the FIFO was full.
//
// Ports (uart_reg_bank_fifo):
//   push_i/data_i  write one entry
//   pop_i          remove the head entry (ignored when empty)
//   flush_i        empty the FIFO; beats a same-cycle push or pop
//   data_o         head entry
//   level_o        number of stored entries, 0..2**AW
//   empty_o/full_o level flags
//   drop_o         a push was discarded because the FIFO was full
module uart_reg_bank_fifo #(
    parameter int AW = 3,
    parameter int W  = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [W-1:0]  data_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [W-1:0]  data_o,
    output logic [AW:0]   level_o,
    output logic          empty_o,
    output logic          full_o,
    output logic          drop_o
);

    localparam int          DEPTH    = 2 ** AW;
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q,  level_d;
    logic          push_ok, pop_ok;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == FULL_LVL);
    assign data_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // accepted when it coincides with a successful pop.
    assign pop_ok  = pop_i && !empty_o && !flush_i;
    assign push_ok = push_i && (!full_o || pop_ok) && !flush_i;
    assign drop_o  = push_i && full_o && !pop_ok && !flush_i;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            level_d = level_q + (AW + 1)'(push_ok) - (AW + 1)'(pop_ok);
        end
    end

    // NOTE: the storage array has no reset; the level/pointers alone decide
    // which entries are valid, and leaving it out keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

module uart_reg_bank #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_6000,
    parameter int          FIFO_AW   = 3,
    parameter int          DATA_W    = 8,
    parameter int          DIV_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       daddr_i,
    input  logic [31:0]       dwdata_i,
    output logic [31:0]       drdata_o,
    input  logic [3:0]        dstrb_i,
    input  logic              dwrite_i,
    input  logic              dvalid_i,
    output logic              dready_o,
    output logic              tx_en_o,
    input  logic              tx_rd_en_i,
    output logic [DATA_W-1:0] tx_data_o,
    output logic              tx_empty_o,
    output logic              rx_en_o,
    input  logic              rx_wr_en_i,
    input  logic [DATA_W-1:0] rx_data_i,
    output logic              rx_full_o,
    output logic [DIV_W-1:0]  baud_div_o,
    output logic              irq_o
);

    localparam logic [7:0]  OFF_TXDATA   = 8'h00;
    localparam logic [7:0]  OFF_TXCTRL   = 8'h04;
    localparam logic [7:0]  OFF_RXDATA   = 8'h08;
    localparam logic [7:0]  OFF_RXCTRL   = 8'h0C;
    localparam logic [7:0]  OFF_BAUDDIV  = 8'h10;
    localparam logic [7:0]  OFF_STATUS   = 8'h14;
    localparam logic [7:0]  OFF_IRQ_EN   = 8'h18;
    localparam logic [7:0]  OFF_IRQ_STAT = 8'h1C;
    localparam logic [31:0] RD_UNMAPPED  = 32'hDEAD_DEAD;
    localparam logic [31:0] RD_RX_EMPTY  = 32'h8000_0000;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic        dready_q, dready_d;
    logic [31:0] drdata_q, drdata_d;
    logic        hit, accept, wr_acc, rd_acc;
    logic [7:0]  off;
    logic [31:0] byte_mask;

    assign hit       = ((daddr_i & 32'hFFFF_F000) == BASE_ADDR);
    assign off       = daddr_i[7:0];
    // No new request is taken while the previous completion pulse is out.
    assign accept    = dvalid_i && hit && !dready_q;
    assign wr_acc    = accept && dwrite_i;
    assign rd_acc    = accept && !dwrite_i;
    assign byte_mask = {{8{dstrb_i[3]}}, {8{dstrb_i[2]}}, {8{dstrb_i[1]}}, {8{dstrb_i[0]}}};

    logic wr_txdata, wr_txctrl_b0, wr_txctrl_b1, wr_rxctrl_b0, wr_rxctrl_b1;
    logic wr_bauddiv, wr_irq_en_b0, wr_irq_stat_b0;
    logic tx_flush, rx_flush, rd_rxdata;

    assign wr_txdata      = wr_acc && (off == OFF_TXDATA)   && dstrb_i[0];
    assign wr_txctrl_b0   = wr_acc && (off == OFF_TXCTRL)   && dstrb_i[0];
    assign wr_txctrl_b1   = wr_acc && (off == OFF_TXCTRL)   && dstrb_i[1];
    assign wr_rxctrl_b0   = wr_acc && (off == OFF_RXCTRL)   && dstrb_i[0];
    assign wr_rxctrl_b1   = wr_acc && (off == OFF_RXCTRL)   && dstrb_i[1];
    assign wr_bauddiv     = wr_acc && (off == OFF_BAUDDIV);
    assign wr_irq_en_b0   = wr_acc && (off == OFF_IRQ_EN)   && dstrb_i[0];
    assign wr_irq_stat_b0 = wr_acc && (off == OFF_IRQ_STAT) && dstrb_i[0];
    assign tx_flush       = wr_txctrl_b0 && dwdata_i[1];
    assign rx_flush       = wr_rxctrl_b0 && dwdata_i[1];
    assign rd_rxdata      = rd_acc && (off == OFF_RXDATA);

    // ------------------------------------------------------------------
    // FIFOs
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] tx_head, rx_head;
    logic [FIFO_AW:0]  tx_level, rx_level;
    logic              tx_empty, tx_full, tx_drop;
    logic              rx_empty, rx_full, rx_drop;

    uart_reg_bank_fifo #(.AW(FIFO_AW), .W(DATA_W)) u_tx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (wr_txdata),
        .data_i  (dwdata_i[DATA_W-1:0]),
        .pop_i   (tx_rd_en_i),
        .flush_i (tx_flush),
        .data_o  (tx_head),
        .level_o (tx_level),
        .empty_o (tx_empty),
        .full_o  (tx_full),
        .drop_o  (tx_drop)
    );

    uart_reg_bank_fifo #(.AW(FIFO_AW), .W(DATA_W)) u_rx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (rx_wr_en_i),
        .data_i  (rx_data_i),
        .pop_i   (rd_rxdata),
        .flush_i (rx_flush),
        .data_o  (rx_head),
        .level_o (rx_level),
        .empty_o (rx_empty),
        .full_o  (rx_full),
        .drop_o  (rx_drop)
    );

    // ------------------------------------------------------------------
    // Control registers and sticky flags
    // ------------------------------------------------------------------
    logic              tx_en_q,  tx_en_d;
    logic              rx_en_q,  rx_en_d;
    logic [7:0]        tx_wm_q,  tx_wm_d;
    logic [7:0]        rx_wm_q,  rx_wm_d;
    logic [DIV_W-1:0]  baud_q,   baud_d;
    logic              tx_ovf_q, tx_ovf_d;
    logic              rx_ovf_q, rx_ovf_d;
    logic              rx_unf_q, rx_unf_d;
    logic [2:0]        w1c;
    logic              rx_unf_set;
    logic              tx_low, rx_high;
    logic [4:0]        irq_stat;
    logic [4:0]        irq_en_rd;

    assign rx_unf_set = rd_rxdata && rx_empty;
    assign w1c        = wr_irq_stat_b0 ? dwdata_i[4:2] : 3'b000;
    assign tx_low     = (8'(tx_level) <= tx_wm_q);
    assign rx_high    = (8'(rx_level) >= rx_wm_q) && !rx_empty;
    assign irq_stat   = {rx_unf_q, rx_ovf_q, tx_ovf_q, rx_high, tx_low};

    always_comb begin
        tx_en_d = tx_en_q;
        rx_en_d = rx_en_q;
        tx_wm_d = tx_wm_q;
        rx_wm_d = rx_wm_q;
        baud_d  = baud_q;
        if (wr_txctrl_b0) tx_en_d = dwdata_i[0];
        if (wr_txctrl_b1) tx_wm_d = dwdata_i[15:8];
        if (wr_rxctrl_b0) rx_en_d = dwdata_i[0];
        if (wr_rxctrl_b1) rx_wm_d = dwdata_i[15:8];
        if (wr_bauddiv) begin
            baud_d = (baud_q & ~byte_mask[DIV_W-1:0]) |
                     (dwdata_i[DIV_W-1:0] & byte_mask[DIV_W-1:0]);
        end
        // Set terms are OR-ed after the clear so a same-cycle event wins.
        tx_ovf_d = (tx_ovf_q && !w1c[0]) || tx_drop;
        rx_ovf_d = (rx_ovf_q && !w1c[1]) || rx_drop;
        rx_unf_d = (rx_unf_q && !w1c[2]) || rx_unf_set;
    end

    // ------------------------------------------------------------------
    // Read mux, sampled into drdata_q on accept
    // ------------------------------------------------------------------
    logic [31:0] rdata;

    always_comb begin
        rdata = RD_UNMAPPED;
        case (off)
            OFF_TXDATA:   rdata = 32'h0;
            OFF_TXCTRL:   rdata = {16'h0, tx_wm_q, 7'h0, tx_en_q};
            OFF_RXDATA:   rdata = rx_empty ? RD_RX_EMPTY : 32'(rx_head);
            OFF_RXCTRL:   rdata = {16'h0, rx_wm_q, 7'h0, rx_en_q};
            OFF_BAUDDIV:  rdata = 32'(baud_q);
            OFF_STATUS:   rdata = {8'h0, 8'(rx_level), 8'(tx_level), 4'h0,
                                   rx_full, rx_empty, tx_full, tx_empty};
            OFF_IRQ_EN:   rdata = 32'(irq_en_rd);
            OFF_IRQ_STAT: rdata = 32'(irq_stat);
            default:      rdata = RD_UNMAPPED;
        endcase
    end

    assign dready_d = accept;
    assign drdata_d = rd_acc ? rdata : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dready_q <= 1'b0;
            drdata_q <= '0;
            tx_en_q  <= 1'b0;
            rx_en_q  <= 1'b0;
            tx_wm_q  <= '0;
            rx_wm_q  <= '0;
            baud_q   <= '0;
            tx_ovf_q <= 1'b0;
            rx_ovf_q <= 1'b0;
            rx_unf_q <= 1'b0;
        end else begin
            dready_q <= dready_d;
            drdata_q <= drdata_d;
            tx_en_q  <= tx_en_d;
            rx_en_q  <= rx_en_d;
            tx_wm_q  <= tx_wm_d;
            rx_wm_q  <= rx_wm_d;
            baud_q   <= baud_d;
            tx_ovf_q <= tx_ovf_d;
            rx_ovf_q <= rx_ovf_d;
            rx_unf_q <= rx_unf_d;
        end
    end

    // ------------------------------------------------------------------
    // Interrupt enable and registered interrupt
    // ------------------------------------------------------------------
`ifdef UART_REG_BANK_IRQ_EN
    logic [4:0] irq_en_q, irq_en_d;
    logic       irq_q,    irq_d;

    assign irq_en_d = wr_irq_en_b0 ? dwdata_i[4:0] : irq_en_q;
    assign irq_d    = |(irq_stat & irq_en_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign irq_en_rd = irq_en_q;
    assign irq_o     = irq_q;
`else
    logic unused_irq_en_wr;
    assign unused_irq_en_wr = wr_irq_en_b0;
    assign irq_en_rd        = 5'h0;
    assign irq_o            = 1'b0;
`endif

    // Write-data bits that no register decodes for this parameter set.
    logic unused_wdata;
    assign unused_wdata = ^dwdata_i;

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign drdata_o   = drdata_q;
    assign dready_o   = dready_q;
    assign tx_en_o    = tx_en_q;
    assign tx_data_o  = tx_head;
    assign tx_empty_o = tx_empty;
    assign rx_en_o    = rx_en_q;
    assign rx_full_o  = rx_full;
    assign baud_div_o = baud_q;

endmodule
